// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide unit: one shift-add or restoring-divide
// step per cycle, with single-cycle fast paths for divide-by-zero and signed overflow.
//
// state  | meaning
// IDLE   | waiting for Start
// RUN    | DATA_WIDTH iteration steps in progress (Busy high)
// DONE   | Result valid for one cycle (Done high), Start may be accepted again
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Start,
  input  logic [2:0]            MDControl,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] Result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_op;
  logic            r_neg;
  logic [W-1:0]    r_hi, r_lo, r_b;
  logic [W-1:0]    r_result;

  logic            w_accept, w_fast, w_sa, w_sb, w_a_neg, w_b_neg, w_neg;
  logic            w_div_zero, w_div_ovf;
  logic [W-1:0]    w_a_mag, w_b_mag, w_fast_res;
  logic [W:0]      w_sum, w_sh, w_diff;
  logic [W-1:0]    w_hi_nxt, w_lo_nxt, w_quo, w_rem, w_run_res;
  logic [2*W-1:0]  w_prod, w_prod_s;

  // Operand decode at accept time
  always_comb begin
    w_sa       = (MDControl == 3'b001) || (MDControl == 3'b010) ||
                 (MDControl == 3'b100) || (MDControl == 3'b110);
    w_sb       = (MDControl == 3'b001) || (MDControl == 3'b100) || (MDControl == 3'b110);
    w_a_neg    = w_sa & SrcA[W-1];
    w_b_neg    = w_sb & SrcB[W-1];
    w_a_mag    = w_a_neg ? -SrcA : SrcA;
    w_b_mag    = w_b_neg ? -SrcB : SrcB;
    w_neg      = (MDControl[2] & MDControl[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
    w_div_zero = MDControl[2] && (SrcB == '0);
    w_div_ovf  = MDControl[2] && !MDControl[0] && (SrcA == MOST_NEG) && (SrcB == '1);
    w_fast     = w_div_zero || w_div_ovf;
    if (w_div_zero) w_fast_res = MDControl[1] ? SrcA : '1;
    else            w_fast_res = MDControl[1] ? '0 : MOST_NEG;
  end

  // One iteration step; r_hi/r_lo hold product halves or remainder/quotient
  always_comb begin
    w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_sh   = {r_hi, r_lo[W-1]};
    w_diff = w_sh - {1'b0, r_b};
    if (!r_op[2]) begin
      w_hi_nxt = w_sum[W:1];
      w_lo_nxt = {w_sum[0], r_lo[W-1:1]};
    end else if (!w_diff[W]) begin
      w_hi_nxt = w_diff[W-1:0];
      w_lo_nxt = {r_lo[W-2:0], 1'b1};
    end else begin
      w_hi_nxt = w_sh[W-1:0];
      w_lo_nxt = {r_lo[W-2:0], 1'b0};
    end
  end

  always_comb begin
    w_prod   = {w_hi_nxt, w_lo_nxt};
    w_prod_s = r_neg ? -w_prod : w_prod;
    w_quo    = r_neg ? -w_lo_nxt : w_lo_nxt;
    w_rem    = r_neg ? -w_hi_nxt : w_hi_nxt;
    if (r_op[2])              w_run_res = r_op[1] ? w_rem : w_quo;
    else if (r_op[1:0] == 2'b00) w_run_res = w_prod_s[W-1:0];
    else                      w_run_res = w_prod_s[2*W-1:W];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    Busy        = 1'b0;
    Done        = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        Done = (r_state == S_DONE);
        if (Start) begin
          w_accept    = 1'b1;
          w_state_nxt = w_fast ? S_DONE : S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        Busy = 1'b1;
        if (r_cnt == LAST) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op  <= MDControl;
        r_neg <= w_neg;
        r_hi  <= '0;
        r_lo  <= w_a_mag;
        r_b   <= w_b_mag;
        r_cnt <= '0;
        if (w_fast) r_result <= w_fast_res;
      end else if (r_state == S_RUN) begin
        r_hi  <= w_hi_nxt;
        r_lo  <= w_lo_nxt;
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == LAST) r_result <= w_run_res;
      end
    end
  end

  assign Result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected results and Done
// timing; a negedge monitor pops and compares whenever Done is seen.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Start;
  logic [2:0]  MDControl;
  logic [31:0] SrcA, SrcB;
  logic        Busy, Done;
  logic [31:0] Result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  op;
    int          cyc;
    int          busy;
  } exp_t;

  exp_t sb_q[$];

  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .MDControl(MDControl),
    .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .Done(Done), .Result(Result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          ia, ib;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    ia = a;
    ib = b;
    p  = '0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic fast;
    fast   = op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    e.res  = ref_model(op, a, b);
    e.op   = op;
    e.cyc  = cyc + (fast ? 1 : 33);
    e.busy = fast ? 0 : 32;
    sb_q.push_back(e);
    MDControl = op;
    SrcA      = a;
    SrcB      = b;
    Start     = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (Done) return;
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: no Done within 60 cycles, required a Done pulse");
  endtask

  // Monitor
  int          busy_cnt = 0;
  logic [31:0] last_res = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
      last_res = '0;
    end else begin
      if (Busy) busy_cnt++;
      if (Done) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_done: Done=1 at cycle %0d, required no Done", cyc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if (Result !== e.res) begin
            errors++;
            $display("FAIL result op=%0d: got %h, required %h", e.op, Result, e.res);
          end
          checks++;
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL done_timing op=%0d: Done after edge %0d, required %0d",
                     e.op, cyc, e.cyc);
          end
          checks++;
          if (busy_cnt != e.busy) begin
            errors++;
            $display("FAIL busy_cycles op=%0d: got %0d, required %0d", e.op, busy_cnt, e.busy);
          end
        end
        busy_cnt = 0;
        last_res = Result;
      end else if (Result !== last_res) begin
        checks++;
        errors++;
        $display("FAIL result_hold: Result changed to %h without Done, required %h",
                 Result, last_res);
        last_res = Result;
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    Start     = 1'b0;
    MDControl = '0;
    SrcA      = '0;
    SrcB      = '0;
    #12;
    checks += 3;
    if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", Busy); end
    if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", Done); end
    if (Result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h, required 0", Result); end
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed vectors, first accept right after release
    issue(3'd0, 32'd7, 32'hFFFF_FFFD);         wait_done();
    issue(3'd1, 32'h8000_0000, 32'h8000_0000); wait_done();
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done();
    issue(3'd2, 32'hFFFF_FFFF, 32'd2);         wait_done();
    issue(3'd4, 32'hFFFF_FFF9, 32'd2);         wait_done();
    issue(3'd6, 32'hFFFF_FFF9, 32'd2);         wait_done();
    issue(3'd5, 32'd100, 32'd7);               wait_done();
    issue(3'd7, 32'd100, 32'd7);               wait_done();
    issue(3'd5, 32'd5, 32'd0);                 wait_done();
    issue(3'd6, 32'd5, 32'd0);                 wait_done();
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF); wait_done();
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF); wait_done();
    @(posedge clk); #1;

    // Start pulsed mid-RUN must be ignored
    issue(3'd0, 32'd7, 32'hFFFF_FFFD);
    repeat (5) @(posedge clk);
    #1;
    Start = 1'b1; MDControl = 3'd5; SrcA = 32'd1000; SrcB = 32'd3;
    @(posedge clk);
    #1 Start = 1'b0;
    wait_done();
    // Back-to-back from the DONE cycle
    issue(3'd4, 32'hFFFF_FF00, 32'd7);
    wait_done();
    @(posedge clk); #1;

    // Reset during RUN aborts with no Done
    issue(3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks += 3;
    if (Busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, required 0", Busy); end
    if (Done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b, required 0", Done); end
    if (Result !== 32'h0) begin errors++; $display("FAIL abort_result: got %h, required 0", Result); end
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    @(posedge clk); #1;

    // Randomized traffic with biased corner operands and random idle gaps
    for (int i = 0; i < 200; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      int          sel;
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'h0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 15));
      else if (sel == 3) a = 32'h8000_0000;
      issue(op, a, b);
      wait_done();
      if ($urandom_range(0, 2) != 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    repeat (3) @(negedge clk);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
